// File: rtl/jtcps1_layer_mix.sv
// -----------------------------------------------------------------------------
// jtcps1_layer_mix
//
// Line compositor for LAYERS tilemap layers. Each layer writes its pixels into
// a private line buffer. Once every enabled layer has reported done, the
// block walks the line column by column. For each column it picks the topmost
// opaque pixel, using the layer order captured at line start. The merged
// pixel goes to the frame buffer through a write/accept handshake.
//
// Optional build macro: JTCPS1_MIX_TIMEOUT_EN
//   When defined, a TOW-bit counter bounds the wait for layer done reports.
//   Layers that have not reported done are treated as transparent.
//   mix_timeout latches high until reset.
//   When undefined, the block waits for done reports indefinitely and
//   mix_timeout is constant 0.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : line start pulse; aborts any line in progress
//   layer_en      : per-layer enable, captured at start
//   layer_order   : LAYERS 3-bit layer indexes, slot 0 (bits 2:0) topmost,
//                   captured at start
//   scr_addr/data : packed per-layer line buffer write address / data
//   scr_wr        : per-layer write strobe (accepted in every state)
//   scr_done      : per-layer "line rendered" pulse
//   line_data     : {layer id, pixel} zero-extended to 12 bits, or BACKDROP
//   line_addr     : column being written
//   line_wr       : write request, held until line_wr_ok
//   line_wr_ok    : frame buffer accepts the current write
//   line_done     : one-cycle pulse after the last column is accepted
//   mix_timeout   : sticky flag, a line was mixed after a done-wait timeout
// -----------------------------------------------------------------------------
module jtcps1_layer_mix #(
    parameter int          LAYERS   = 3,
    parameter int          AW       = 9,
    parameter int          DW       = 9,
    parameter int          PIXELS   = 384,
    parameter logic [11:0] BACKDROP = 12'hFFF,
    parameter int          TOW      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LAYERS-1:0]      layer_en,
    input  logic [LAYERS*3-1:0]    layer_order,
    input  logic [LAYERS*AW-1:0]   scr_addr,
    input  logic [LAYERS*DW-1:0]   scr_data,
    input  logic [LAYERS-1:0]      scr_wr,
    input  logic [LAYERS-1:0]      scr_done,
    output logic [11:0]            line_data,
    output logic [AW-1:0]          line_addr,
    output logic                   line_wr,
    input  logic                   line_wr_ok,
    output logic                   line_done,
    output logic                   mix_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_READ  = 3'd2,
        ST_PICK  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [LAYERS-1:0]   r_en;
    logic [LAYERS*3-1:0] r_order;
    logic [LAYERS-1:0]   r_done;
    logic [LAYERS-1:0]   r_use;     // layers that contribute to this line
    logic [AW-1:0]       r_col;
    logic [DW-1:0]       r_mem [LAYERS][2**AW];
    logic [DW-1:0]       r_rd  [LAYERS];

    logic                w_all_done;
    logic                w_fill_ok;
    logic                w_last_col;
    logic                w_found;
    logic                w_hit;
    logic [11:0]         w_pick;

    assign w_all_done = ((r_done & r_en) == r_en);
    assign w_last_col = (r_col == AW'(PIXELS - 1));

    // Line buffer write ports: layers may refill their buffers at any time.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LAYERS; i++) begin
            if (scr_wr[i]) begin
                r_mem[i][scr_addr[i*AW +: AW]] <= scr_data[i*DW +: DW];
            end
        end
    end

    // Line buffer read ports: one-cycle latency, data is consumed in PICK.
    always_ff @(posedge clk) begin
        if (r_state == ST_READ) begin
            for (int i = 0; i < LAYERS; i++) begin
                r_rd[i] <= r_mem[i][r_col];
            end
        end
    end

    // Priority resolve: the first slot naming an enabled layer with an opaque
    // pixel wins. Slots holding an index >= LAYERS never match any layer.
    // A duplicate index also loses to the earlier slot.
    always_comb begin
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_pick  = BACKDROP;
        for (int s = 0; s < LAYERS; s++) begin
            for (int l = 0; l < LAYERS; l++) begin
                w_hit   = !w_found && (r_order[s*3 +: 3] == 3'(l)) &&
                          r_use[l] && (r_rd[l][3:0] != 4'hF);
                w_pick  = w_hit ? 12'({3'(l), r_rd[l]}) : w_pick;
                w_found = w_found | w_hit;
            end
        end
    end

`ifdef JTCPS1_MIX_TIMEOUT_EN
    logic [TOW-1:0] r_to_cnt;
    logic           r_timeout;
    logic           w_to_hit;

    assign w_to_hit    = (r_to_cnt == {TOW{1'b1}});
    assign w_fill_ok   = w_all_done | w_to_hit;
    assign mix_timeout = r_timeout;

    // Done-wait watchdog: counts FILL cycles and restarts on every new line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (start || r_state != ST_FILL) begin
            r_to_cnt  <= '0;
        end else begin
            r_to_cnt  <= w_to_hit ? r_to_cnt : r_to_cnt + TOW'(1);
            if (w_to_hit && !w_all_done) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_fill_ok   = w_all_done;
    // TOW only sizes the watchdog counter; without it the flag is constant 0.
    assign mix_timeout = (TOW < 0) ? 1'b1 : 1'b0;
`endif

    // Next-state logic; start overrides every state, including mid-line.
    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = ST_FILL;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nx = ST_IDLE;
                ST_FILL:  w_state_nx = w_fill_ok ? ST_READ : ST_FILL;
                ST_READ:  w_state_nx = ST_PICK;
                ST_PICK:  w_state_nx = ST_WRITE;
                ST_WRITE: begin
                    if (line_wr_ok) begin
                        w_state_nx = w_last_col ? ST_DONE : ST_READ;
                    end else begin
                        w_state_nx = ST_WRITE;
                    end
                end
                ST_DONE:  w_state_nx = ST_IDLE;
                default:  w_state_nx = ST_IDLE;
            endcase
        end
    end

    // State, captured line configuration, done flags, column and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_en      <= '0;
            r_order   <= '0;
            r_done    <= '0;
            r_use     <= '0;
            r_col     <= '0;
            line_data <= 12'h000;
            line_addr <= '0;
            line_wr   <= 1'b0;
            line_done <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            line_done <= (w_state_nx == ST_DONE);
            // a done pulse coinciding with start belongs to the old line
            r_done    <= start ? '0 : (r_done | scr_done);
            if (start) begin
                r_en    <= layer_en;
                r_order <= layer_order;
                line_wr <= 1'b0;
            end else begin
                case (r_state)
                    ST_FILL: begin
                        if (w_fill_ok) begin
                            r_col <= '0;
                            // late layers (timeout case) are left out of the mix
                            r_use <= r_en & r_done;
                        end
                    end
                    ST_PICK: begin
                        line_data <= w_pick;
                        line_addr <= r_col;
                        line_wr   <= 1'b1;
                    end
                    ST_WRITE: begin
                        if (line_wr_ok) begin
                            line_wr <= 1'b0;
                            if (!w_last_col) begin
                                r_col <= r_col + AW'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_layer_mix.sv
// Scoreboard bench for jtcps1_layer_mix (default parameters).
// Stimulus runs at posedge+1; the monitor samples on the negative edge.
module tb_jtcps1_layer_mix;

    localparam int LAYERS = 3;
    localparam int AW     = 9;
    localparam int DW     = 9;
    localparam int PIXELS = 384;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [LAYERS-1:0]     layer_en;
    logic [LAYERS*3-1:0]   layer_order;
    logic [LAYERS*AW-1:0]  scr_addr;
    logic [LAYERS*DW-1:0]  scr_data;
    logic [LAYERS-1:0]     scr_wr;
    logic [LAYERS-1:0]     scr_done;
    logic [11:0]           line_data;
    logic [AW-1:0]         line_addr;
    logic                  line_wr;
    logic                  line_wr_ok;
    logic                  line_done;
    logic                  mix_timeout;

    jtcps1_layer_mix dut (
        .clk(clk), .rst(rst), .start(start),
        .layer_en(layer_en), .layer_order(layer_order),
        .scr_addr(scr_addr), .scr_data(scr_data),
        .scr_wr(scr_wr), .scr_done(scr_done),
        .line_data(line_data), .line_addr(line_addr),
        .line_wr(line_wr), .line_wr_ok(line_wr_ok),
        .line_done(line_done), .mix_timeout(mix_timeout)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic [20:0] exp_q[$];
    int          done_q[$];
    logic [11:0] exp_line [PIXELS];
    logic [8:0]  pix [LAYERS][PIXELS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected none at %0t", name, act, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // fill exp_line with backdrop; the caller overrides the opaque columns
    task automatic exp_clear;
        for (int c = 0; c < PIXELS; c++) exp_line[c] = 12'hFFF;
    endtask

    task automatic exp_push;
        for (int c = 0; c < PIXELS; c++) exp_q.push_back({9'(c), exp_line[c]});
        done_q.push_back(1);
        acc_cnt = 0;
    endtask

    task automatic start_line(input logic [2:0] en, input logic [8:0] order);
        layer_en    = en;
        layer_order = order;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic pulse_done(input logic [2:0] m);
        scr_done = m;
        tick();
        scr_done = 3'b000;
    endtask

    task automatic wait_col(input int col);
        int n;
        n = 0;
        while (!(line_wr && line_addr == 9'(col)) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) fail("wait_col_timeout", 32'(col));
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
        if (done_cnt == d0) fail({name, "_line_done_timeout"}, 32'(d0));
        chk({name, "_accepted_writes"}, 32'(acc_cnt), 32'(PIXELS));
        tick();
        tick();
        chk({name, "_done_low_after"}, 32'(line_done), 32'd0);
    endtask

    // Scoreboard monitor: every accepted write and every line_done pulse
    // consumes one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (line_wr && line_wr_ok) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    fail("unexpected_write", {11'd0, line_addr, line_data});
                end else begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(line_addr), 32'(e[20:12]));
                    chk("wr_data", 32'(line_data), 32'(e[11:0]));
                end
            end
            if (line_done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    fail("unexpected_line_done", 32'(done_cnt));
                end else begin
                    void'(done_q.pop_front());
                    chk("done_after_all_writes", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; layer_en = '0; layer_order = '0;
        scr_addr = '0; scr_data = '0; scr_wr = '0; scr_done = '0;
        line_wr_ok = 1'b1;
        repeat (3) tick();
        chk("rst_line_data", 32'(line_data), 32'd0);
        chk("rst_line_addr", 32'(line_addr), 32'd0);
        chk("rst_line_wr", 32'(line_wr), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_mix_timeout", 32'(mix_timeout), 32'd0);
        rst = 1'b0;

        // Buffer contents: transparent everywhere except a few columns
        for (int l = 0; l < LAYERS; l++)
            for (int c = 0; c < PIXELS; c++) pix[l][c] = 9'h00F;
        pix[0][0] = 9'h100; pix[0][5] = 9'h003; pix[0][9] = 9'h00A;
        pix[1][4] = 9'h011; pix[1][5] = 9'h011; pix[1][383] = 9'h0F0;
        pix[2][8] = 9'h1A5; pix[2][9] = 9'h1B3;
        for (int c = 0; c < PIXELS; c++) begin
            scr_addr = {9'(c), 9'(c), 9'(c)};
            scr_data = {pix[2][c], pix[1][c], pix[0][c]};
            scr_wr   = 3'b111;
            tick();
        end
        scr_wr = 3'b000;

        // Line A: order slot0=0, slot1=1, slot2=2, all enabled, stall at col 7
        exp_clear();
        exp_line[0] = 12'h100; exp_line[4] = 12'h211; exp_line[5] = 12'h003;
        exp_line[8] = 12'h5A5; exp_line[9] = 12'h00A; exp_line[383] = 12'h2F0;
        exp_push();
        start_line(3'b111, {3'd2, 3'd1, 3'd0});
        pulse_done(3'b111);
        wait_col(7);
        line_wr_ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_line_wr", 32'(line_wr), 32'd1);
            chk("stall_line_addr", 32'(line_addr), 32'd7);
            chk("stall_line_data", 32'(line_data), 32'hFFF);
        end
        line_wr_ok = 1'b1;
        wait_done("lineA");

        // Line B: layer0 column 5 made transparent, aborted at col 100
        scr_addr = {9'd0, 9'd0, 9'd5};
        scr_data = {9'd0, 9'd0, 9'h00F};
        scr_wr   = 3'b001;
        tick();
        scr_wr   = 3'b000;
        exp_clear();
        exp_line[0] = 12'h100; exp_line[4] = 12'h211; exp_line[5] = 12'h211;
        exp_line[8] = 12'h5A5; exp_line[9] = 12'h00A; exp_line[383] = 12'h2F0;
        exp_push();
        start_line(3'b111, {3'd2, 3'd1, 3'd0});
        pulse_done(3'b111);
        wait_col(100);
        start    = 1'b1;
        scr_done = 3'b111;
        tick();
        start    = 1'b0;
        scr_done = 3'b000;
        chk("abort_line_wr_low", 32'(line_wr), 32'd0);
        exp_q.delete();
        done_q.delete();
        exp_push();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_fill_waits", 32'(line_wr), 32'd0);
        end
        pulse_done(3'b111);
        wait_done("lineB");

        // Line C: layer 1 disabled and never reports done
        exp_clear();
        exp_line[0] = 12'h100; exp_line[8] = 12'h5A5; exp_line[9] = 12'h00A;
        exp_push();
        start_line(3'b101, {3'd2, 3'd1, 3'd0});
        pulse_done(3'b101);
        wait_done("lineC");

        // Line D: slot0=2, slot1=7 (skipped), slot2=0
        exp_clear();
        exp_line[0] = 12'h100; exp_line[8] = 12'h5A5; exp_line[9] = 12'h5B3;
        exp_push();
        start_line(3'b111, {3'd0, 3'd7, 3'd2});
        pulse_done(3'b111);
        wait_done("lineD");

        chk("end_mix_timeout", 32'(mix_timeout), 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtcps1_layer_mix.md
Name: jtcps1_layer_mix

Overview:
- N-layer line compositor.
- Captures per-layer pixel streams from tilemap engines into internal line buffers and waits for every enabled layer to report done.
- Resolves per-pixel priority using a run-time layer order, then streams the merged line to the frame buffer with a ready handshake.
- Parametrised successor to the fixed three-scroll colour mixer; supports any layer count and run-time ordering/enables.

Parameters:
- LAYERS, 3, number of input layers (1..8)
- AW, 9, line buffer address width; buffer depth 2**AW
- DW, 9, layer pixel width; bits [3:0] are the colour index, 4'hF is transparent
- PIXELS, 384, pixels emitted per line (must be ≤ 2**AW)
- BACKDROP, 12'hFFF, line_data value when no layer is opaque
- TOW, 16, timeout counter width (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  line start pulse
- layer_en  in  LAYERS  per-layer enable
- layer_order  in  LAYERS*3  packed layer indexes; slot 0 (bits 2:0) is topmost
- scr_addr  in  LAYERS*AW  packed write addresses
- scr_data  in  LAYERS*DW  packed write data
- scr_wr  in  LAYERS  per-layer write strobe
- scr_done  in  LAYERS  per-layer done pulse
- line_data  out  12  {layer id[2:0], pixel[DW-1:0]} or BACKDROP
- line_addr  out  AW  pixel column
- line_wr  out  1  write request
- line_wr_ok  in  1  frame buffer accept
- line_done  out  1  one-cycle end-of-line pulse
- mix_timeout  out  1  sticky timeout flag

Interface (already decided):
- One clock; reset is synchronous and active-high. Ports are named clk and rst.

Behaviour:
- Reset: line_data=0, line_addr=0, line_wr=0, line_done=0, mix_timeout=0; state IDLE; done flags cleared.
  - Reset takes effect on the next edge, from any state.
- Buffers:
  - One simple dual-port RAM per layer: write on scr_wr[i], at any time, in any state.
  - Read latency is 1 cycle.
- Done flags:
  - Sticky; set by scr_done[i]; all flags cleared by start.
  - If start and scr_done[i] occur in the same cycle, start wins and the flag stays clear.
- Sampling: layer_en and layer_order are registered on start and held for the whole line.
- States:
  - IDLE: wait for start, then go to FILL.
  - FILL: wait until every enabled layer's flag is set (all layers disabled: exit the next cycle). Then set col=0 and go to READ.
  - READ: drive read address col to all buffers; go to PICK.
  - PICK: scan slots 0..LAYERS-1. The first slot whose layer is enabled and whose pixel[3:0] != 4'hF wins.
    - Result line_data = {idx, pixel}.
    - No winner: line_data = BACKDROP.
    - Assert line_wr, line_addr=col; go to WRITE.
  - WRITE: hold line_wr, line_data and line_addr until the cycle in which line_wr_ok=1. Then drop line_wr.
    - If col==PIXELS-1, go to DONE; otherwise col++ and go to READ.
  - DONE: line_done=1 for exactly one cycle; go to IDLE.
- Throughput: at best 3 cycles per pixel with line_wr_ok tied high.
- Start mid-line: start in any non-IDLE state aborts the line.
  - line_wr drops next cycle; flags are cleared; go to FILL; no line_done is emitted for the aborted line.
- Duplicate indexes in layer_order: the earlier slot wins; no error. An index ≥ LAYERS in a slot means that slot is skipped.
- Arithmetic: col is AW bits and never wraps past PIXELS-1. Output widths are fixed by zero-extension.

Optional Feature:
- JTCPS1_MIX_TIMEOUT_EN defined:
  - A TOW-bit counter runs in FILL. On reaching all-ones, FILL exits as if complete.
  - Layers that have not reported done are treated as transparent for that line.
  - mix_timeout is set and stays set until rst.
- Undefined: FILL waits indefinitely; mix_timeout is tied 0.

Test Plan:
- Three layers, order {2,1,0} (slot0=0), all enabled. Layer0 pixel 5 = 9'h003, layer1 pixel 5 = 9'h011 -> line_addr 5 outputs {3'd0, 9'h003}.
- Same data, layer0 pixel 5 = 9'h00F (transparent) -> {3'd1, 9'h011}. All layers transparent at pixel 6 -> 12'hFFF.
- line_wr_ok held low for 10 cycles at col 7 -> line_wr/line_data/line_addr stable for those 10 cycles; exactly 384 accepted writes per line; one line_done pulse.
- layer_en=3'b101, scr_done only on layers 0 and 2 -> mixing starts; layer 1 data (opaque) never appears in the output.
- start asserted at col 100 -> line_wr low next cycle; FILL re-entered; scr_done pulsed in the same cycle as start does not count; no line_done for the aborted line.
- With JTCPS1_MIX_TIMEOUT_EN, TOW=4, layer 2 never done -> FILL exits after 15 cycles; mix_timeout=1; layer 2 is treated transparent.
